ahb_lite_master: RTL

- Single-outstanding-per-stage AHB-Lite initiator. Converts a simple valid/ready command stream into pipelined AHB-Lite SINGLE transfers.
- Returns one in-order response per command.
- Drives the same HADDR/HTRANS/HWRITE/HSIZE/HWDATA bus that our AHB-Lite memory slaves respond on.
- Supports address/data phase overlap, wait states and the two-cycle ERROR response.

---
 rtl/ahb_lite_master_if.sv | 43 ++++
 rtl/ahb_lite_master.sv | 104 ++++++++++
 2 files changed

// File: rtl/ahb_lite_master_if.sv
// Command/response stream plus AHB-Lite bus bundle for ahb_lite_master.
// The master modport is the initiator side; slave is the bus/command peer.
interface ahb_lite_master_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          cmd_valid;
    logic          cmd_ready;
    logic [AW-1:0] cmd_addr;
    logic          cmd_write;
    logic [1:0]    cmd_size;
    logic [DW-1:0] cmd_wdata;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic [AW-1:0] HADDR;
    logic          HWRITE;
    logic [2:0]    HSIZE;
    logic [2:0]    HBURST;
    logic [3:0]    HPROT;
    logic [1:0]    HTRANS;
    logic          HMASTLOCK;
    logic [DW-1:0] HWDATA;
    logic          HREADY;
    logic          HRESP;
    logic [DW-1:0] HRDATA;

    modport master (
        input  cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        input  HREADY, HRESP, HRDATA,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        output HMASTLOCK, HWDATA
    );

    modport slave (
        output cmd_valid, cmd_addr, cmd_write, cmd_size, cmd_wdata,
        output HREADY, HRESP, HRDATA,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  HADDR, HWRITE, HSIZE, HBURST, HPROT, HTRANS,
        input  HMASTLOCK, HWDATA
    );
endinterface

// File: rtl/ahb_lite_master.sv
// AHB-Lite SINGLE-transfer initiator: address slot feeds a data slot,
// with wait-state stalls and two-cycle ERROR handling (retains the queued transfer).
module ahb_lite_master #(
    parameter int         AHB_ADDR_WIDTH = 32,
    parameter int         AHB_DATA_WIDTH = 32,
    parameter logic [3:0] HPROT_VALUE    = 4'b0011
) (
    input logic               HCLK,
    input logic               HRESET,
    ahb_lite_master_if.master bus
);
    localparam int AW = AHB_ADDR_WIDTH;
    localparam int DW = AHB_DATA_WIDTH;

    localparam logic [1:0] TR_IDLE   = 2'b00;
    localparam logic [1:0] TR_NONSEQ = 2'b10;

    logic          r_a_valid;
    logic [AW-1:0] r_a_addr;
    logic          r_a_write;
    logic [1:0]    r_a_size;
    logic [DW-1:0] r_a_wdata;
    logic          r_d_valid;
    logic          r_d_write;
    logic [DW-1:0] r_d_wdata;
    logic          r_err_hold;
    logic          r_rsp_valid;
    logic          r_rsp_err;
    logic [DW-1:0] r_rsp_rdata;

    logic          w_err_first;
    logic          w_cmd_ready;
    logic          w_accept;
    logic          w_issue;
    logic          w_done;
    logic [1:0]    w_size;

    assign w_err_first = bus.HRESP & ~bus.HREADY;
    assign w_cmd_ready = ~HRESET & ~r_err_hold & ~w_err_first
                       & (~r_a_valid | bus.HREADY);
    assign w_accept    = bus.cmd_valid & w_cmd_ready;
    assign w_issue     = r_a_valid & ~r_err_hold;
    assign w_done      = r_d_valid & bus.HREADY;
    assign w_size      = (bus.cmd_size == 2'b11) ? 2'b10 : bus.cmd_size;

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            r_a_valid   <= 1'b0;
            r_a_addr    <= '0;
            r_a_write   <= 1'b0;
            r_a_size    <= 2'b00;
            r_a_wdata   <= '0;
            r_d_valid   <= 1'b0;
            r_d_write   <= 1'b0;
            r_d_wdata   <= '0;
            r_err_hold  <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= '0;
        end else begin
            r_rsp_valid <= w_done;
            if (w_done) begin
                r_rsp_err   <= bus.HRESP;
                r_rsp_rdata <= r_d_write ? '0 : bus.HRDATA;
            end
            // First ERROR cycle freezes issue until the second cycle completes
            if (r_d_valid & w_err_first) begin
                r_err_hold <= 1'b1;
            end else if (bus.HREADY) begin
                r_err_hold <= 1'b0;
            end
            if (bus.HREADY) begin
                r_d_valid <= w_issue;
                if (w_issue) begin
                    r_d_write <= r_a_write;
                    r_d_wdata <= r_a_wdata;
                end
            end
            // An empty slot may be filled even during a wait state
            if (w_accept) begin
                r_a_valid <= 1'b1;
                r_a_addr  <= bus.cmd_addr;
                r_a_write <= bus.cmd_write;
                r_a_size  <= w_size;
                r_a_wdata <= bus.cmd_wdata;
            end else if (bus.HREADY & ~r_err_hold) begin
                r_a_valid <= 1'b0;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;
    assign bus.HADDR     = r_a_addr;
    assign bus.HWRITE    = r_a_write;
    assign bus.HSIZE     = {1'b0, r_a_size};
    assign bus.HBURST    = 3'b000;
    assign bus.HPROT     = HPROT_VALUE;
    assign bus.HTRANS    = w_issue ? TR_NONSEQ : TR_IDLE;
    assign bus.HMASTLOCK = 1'b0;
    assign bus.HWDATA    = r_d_wdata;
endmodule
